// File: rtl/instruction_sequencer_if.sv
// Bundle between the instruction sequencer, its dual-port instruction ROM and
// the downstream command consumer. "master" is the sequencer side.
interface instruction_sequencer_if #(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 16
);
    logic                   start_i;
    logic [ADDR_ROM_SZ-1:0] addr_rom_a_o;
    logic [ADDR_ROM_SZ-1:0] addr_rom_b_o;
    logic [DATA_ROM_SZ-1:0] data_rom_a_i;
    logic [DATA_ROM_SZ-1:0] data_rom_b_i;
    logic [ADDR_ROM_SZ-1:0] addr_rom_a_i;
    logic [DATA_ROM_SZ-3:0] cmd_o;
    logic [DATA_ROM_SZ-1:0] data_o;
    logic [ADDR_ROM_SZ-1:0] pc_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        input  start_i, data_rom_a_i, data_rom_b_i, addr_rom_a_i, ready_i,
        output addr_rom_a_o, addr_rom_b_o, cmd_o, data_o, pc_o, valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, data_rom_a_i, data_rom_b_i, addr_rom_a_i, ready_i,
        input  addr_rom_a_o, addr_rom_b_o, cmd_o, data_o, pc_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Steps through a two-word-per-instruction program held in a registered dual-port
// ROM; ISSUE words go downstream over valid/ready, JUMP/WAIT/END run locally.
module instruction_sequencer #(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    instruction_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_ISSUE = 3'd3,
        S_DELAY = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ISSUE = 2'b00;
    localparam logic [1:0] OP_JUMP  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;

    state_t                 state_q;
    logic [ADDR_ROM_SZ-1:0] pc_q;
    logic [DATA_ROM_SZ-1:0] cnt_q;
    logic [DATA_ROM_SZ-3:0] cmd_q;
    logic [DATA_ROM_SZ-1:0] data_q;
    logic [ADDR_ROM_SZ-1:0] pc_out_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic [ADDR_ROM_SZ-1:0] pc_next_s;
    logic [1:0]             opcode_s;

    // Instruction pairs are two words apart; the adder width gives the wrap for free.
    assign pc_next_s = pc_q + ADDR_ROM_SZ'(2);
    assign opcode_s  = bus.data_rom_a_i[DATA_ROM_SZ-1 -: 2];

    assign bus.addr_rom_a_o = pc_q;
    assign bus.addr_rom_b_o = pc_q + ADDR_ROM_SZ'(1);
    assign bus.cmd_o        = cmd_q;
    assign bus.data_o       = data_q;
    assign bus.pc_o         = pc_out_q;
    assign bus.valid_o      = valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode_s)
                        OP_ISSUE: begin
                            cmd_q    <= bus.data_rom_a_i[DATA_ROM_SZ-3:0];
                            data_q   <= bus.data_rom_b_i;
                            pc_out_q <= bus.addr_rom_a_i;
                            valid_q  <= 1'b1;
                            state_q  <= S_ISSUE;
                        end
                        OP_JUMP: begin
                            pc_q    <= bus.data_rom_a_i[ADDR_ROM_SZ-1:0];
                            state_q <= S_FETCH;
                        end
                        OP_WAIT: begin
                            if (bus.data_rom_b_i != '0) begin
                                cnt_q   <= bus.data_rom_b_i;
                                state_q <= S_DELAY;
                            end else begin
                                pc_q    <= pc_next_s;
                                state_q <= S_FETCH;
                            end
                        end
                        default: begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    endcase
                end
                S_ISSUE: begin
                    // valid_q is always set in this state, so ready alone completes it.
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_next_s;
                        state_q <= S_FETCH;
                    end
                end
                S_DELAY: begin
                    cnt_q <= cnt_q - DATA_ROM_SZ'(1);
                    if (cnt_q == DATA_ROM_SZ'(1)) begin
                        pc_q    <= pc_next_s;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a registered dual-port ROM model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom [16];
    int          tests = 0;
    int          fails = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;

    instruction_sequencer_if #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(16)) bus ();

    instruction_sequencer #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // ROM model: data and echoed address registered one cycle after the address
    always @(posedge clk) begin
        bus.data_rom_a_i <= rom[bus.addr_rom_a_o];
        bus.data_rom_b_i <= rom[bus.addr_rom_b_o];
        bus.addr_rom_a_i <= bus.addr_rom_a_o;
    end

    always @(posedge clk) begin
        if (bus.valid_o && bus.ready_i) xfer_cnt <= xfer_cnt + 1;
        if (bus.done_o) done_cnt <= done_cnt + 1;
    end

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'hC000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic adv(input int m);
        repeat (m) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!bus.busy_o) break;
            @(negedge clk);
        end
        tests++;
        if (bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle busy=%b expected 0", name, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        clear_rom();
        bus.data_rom_a_i = 16'h0000;
        bus.data_rom_b_i = 16'h0000;
        bus.addr_rom_a_i = 4'd0;
        do_reset();
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o} !== {4'd0, 4'd1}) begin
            fails++;
            $display("FAIL reset_addr got %h expected 01", {bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        tests++;
        if ({bus.cmd_o, bus.data_o, bus.pc_o} !== {14'h0, 16'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_payload got %h expected 0", {bus.cmd_o, bus.data_o, bus.pc_o});
        end
        tests++;
        if ({bus.valid_o, bus.busy_o, bus.done_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b expected 000", {bus.valid_o, bus.busy_o, bus.done_o});
        end
    endtask

    task automatic test_issue();
        int x0, d0;
        clear_rom();
        rom[0] = 16'h0012; rom[1] = 16'hABCD; rom[2] = 16'hC000;
        bus.ready_i = 1'b1;
        x0 = xfer_cnt; d0 = done_cnt;
        start_pulse();
        adv(0);
        tests++;
        if ({bus.busy_o, bus.valid_o, bus.addr_rom_a_o, bus.addr_rom_b_o} !== {1'b1, 1'b0, 4'd0, 4'd1}) begin
            fails++;
            $display("FAIL issue_fetch got %h expected 201", {bus.busy_o, bus.valid_o, bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        adv(1);
        tests++;
        if (bus.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL issue_early_valid got %b expected 0", bus.valid_o);
        end
        adv(1);
        tests++;
        if ({bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o} !== {1'b1, 14'h0012, 16'hABCD, 4'd0}) begin
            fails++;
            $display("FAIL issue_payload got %h expected %h", {bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o},
                     {1'b1, 14'h0012, 16'hABCD, 4'd0});
        end
        adv(1);
        tests++;
        if ({bus.valid_o, bus.addr_rom_a_o, bus.addr_rom_b_o} !== {1'b0, 4'd2, 4'd3}) begin
            fails++;
            $display("FAIL issue_next_fetch got %h expected 023", {bus.valid_o, bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        adv(2);
        tests++;
        if ({bus.done_o, bus.busy_o} !== 2'b11) begin
            fails++;
            $display("FAIL issue_done_pulse got %b expected 11", {bus.done_o, bus.busy_o});
        end
        adv(1);
        tests++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            fails++;
            $display("FAIL issue_back_idle got %b expected 00", {bus.done_o, bus.busy_o});
        end
        tests++;
        if ((xfer_cnt - x0) != 1 || (done_cnt - d0) != 1) begin
            fails++;
            $display("FAIL issue_counts xfers=%0d dones=%0d expected 1 1", xfer_cnt - x0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int x0, vcyc;
        clear_rom();
        rom[0] = 16'h0012; rom[1] = 16'hABCD; rom[2] = 16'hC000;
        bus.ready_i = 1'b0;
        x0 = xfer_cnt; vcyc = 0;
        start_pulse();
        adv(2);
        bus.start_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) bus.start_i = 1'b0;
            if (k == 5) bus.ready_i = 1'b1;
            if (bus.valid_o) vcyc++;
            tests++;
            if ({bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o} !== {1'b1, 14'h0012, 16'hABCD, 4'd0}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got %h expected %h", k, {bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o},
                         {1'b1, 14'h0012, 16'hABCD, 4'd0});
            end
            adv(1);
        end
        if (bus.valid_o) vcyc++;
        tests++;
        if (vcyc != 6 || bus.addr_rom_a_o !== 4'd2) begin
            fails++;
            $display("FAIL bp_release valid_cycles=%0d pc=%0d expected 6 2", vcyc, bus.addr_rom_a_o);
        end
        wait_idle("bp");
        tests++;
        if ((xfer_cnt - x0) != 1) begin
            fails++;
            $display("FAIL bp_xfers got %0d expected 1", xfer_cnt - x0);
        end
    endtask

    task automatic test_wait();
        clear_rom();
        rom[0] = 16'h8000; rom[1] = 16'h0004; rom[2] = 16'h0001; rom[3] = 16'h0002;
        bus.ready_i = 1'b1;
        start_pulse();
        adv(5);
        tests++;
        if ({bus.busy_o, bus.valid_o, bus.addr_rom_a_o} !== {1'b1, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL wait_in_delay got %h expected 20", {bus.busy_o, bus.valid_o, bus.addr_rom_a_o});
        end
        adv(1);
        tests++;
        if (bus.addr_rom_a_o !== 4'd2) begin
            fails++;
            $display("FAIL wait_exit pc got %0d expected 2", bus.addr_rom_a_o);
        end
        adv(1);
        tests++;
        if (bus.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL wait_early_valid got %b expected 0", bus.valid_o);
        end
        adv(1);
        tests++;
        if ({bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o} !== {1'b1, 14'h0001, 16'h0002, 4'd2}) begin
            fails++;
            $display("FAIL wait_issue got %h expected %h", {bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o},
                     {1'b1, 14'h0001, 16'h0002, 4'd2});
        end
        wait_idle("wait");

        rom[1] = 16'h0000;
        start_pulse();
        adv(2);
        tests++;
        if (bus.addr_rom_a_o !== 4'd2) begin
            fails++;
            $display("FAIL wait0_fetch pc got %0d expected 2", bus.addr_rom_a_o);
        end
        adv(2);
        tests++;
        if ({bus.valid_o, bus.pc_o} !== {1'b1, 4'd2}) begin
            fails++;
            $display("FAIL wait0_issue got %h expected 12", {bus.valid_o, bus.pc_o});
        end
        wait_idle("wait0");
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = 16'h400E; rom[14] = 16'h0003; rom[15] = 16'h0004;
        bus.ready_i = 1'b1;
        start_pulse();
        adv(2);
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o} !== {4'd14, 4'd15}) begin
            fails++;
            $display("FAIL wrap_fetch14 got %h expected ef", {bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        adv(2);
        tests++;
        if ({bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o} !== {1'b1, 14'h0003, 16'h0004, 4'd14}) begin
            fails++;
            $display("FAIL wrap_issue14 got %h expected %h", {bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o},
                     {1'b1, 14'h0003, 16'h0004, 4'd14});
        end
        adv(1);
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o} !== {4'd0, 4'd1}) begin
            fails++;
            $display("FAIL wrap_to0 got %h expected 01", {bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        do_reset();

        clear_rom();
        rom[0] = 16'h400F; rom[15] = 16'h0005;
        bus.ready_i = 1'b1;
        start_pulse();
        adv(2);
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o} !== {4'd15, 4'd0}) begin
            fails++;
            $display("FAIL wrap_fetch15 got %h expected f0", {bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        adv(2);
        tests++;
        if ({bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o} !== {1'b1, 14'h0005, 16'h400F, 4'd15}) begin
            fails++;
            $display("FAIL wrap_issue15 got %h expected %h", {bus.valid_o, bus.cmd_o, bus.data_o, bus.pc_o},
                     {1'b1, 14'h0005, 16'h400F, 4'd15});
        end
        adv(1);
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o} !== {4'd1, 4'd2}) begin
            fails++;
            $display("FAIL wrap_to1 got %h expected 12", {bus.addr_rom_a_o, bus.addr_rom_b_o});
        end
        wait_idle("wrap");
    endtask

    task automatic test_jump_self();
        clear_rom();
        rom[0] = 16'h4000;
        bus.ready_i = 1'b1;
        start_pulse();
        adv(20);
        bus.start_i = 1'b1;
        adv(1);
        bus.start_i = 1'b0;
        adv(5);
        tests++;
        if ({bus.busy_o, bus.valid_o, bus.done_o, bus.addr_rom_a_o} !== {3'b100, 4'd0}) begin
            fails++;
            $display("FAIL jump_self_loop got %h expected 40", {bus.busy_o, bus.valid_o, bus.done_o, bus.addr_rom_a_o});
        end
        do_reset();
        tests++;
        if (bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL jump_self_reset busy=%b expected 0", bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int x0;
        clear_rom();
        rom[0] = 16'h0012; rom[1] = 16'hABCD;
        bus.ready_i = 1'b0;
        start_pulse();
        adv(2);
        x0 = xfer_cnt;
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o, bus.cmd_o, bus.data_o, bus.pc_o, bus.valid_o, bus.busy_o, bus.done_o}
            !== {4'd0, 4'd1, 14'h0, 16'h0, 4'd0, 3'b000}) begin
            fails++;
            $display("FAIL rst_in_issue got %h", {bus.addr_rom_a_o, bus.addr_rom_b_o, bus.cmd_o, bus.data_o, bus.pc_o,
                     bus.valid_o, bus.busy_o, bus.done_o});
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ((xfer_cnt - x0) != 0 || bus.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_xfer xfers=%0d valid=%b expected 0 0", xfer_cnt - x0, bus.valid_o);
        end
        @(negedge clk);
        rst = 1'b0;

        clear_rom();
        rom[0] = 16'h8000; rom[1] = 16'h0004;
        start_pulse();
        adv(3);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({bus.addr_rom_a_o, bus.addr_rom_b_o, bus.valid_o, bus.busy_o, bus.done_o} !== {4'd0, 4'd1, 3'b000}) begin
            fails++;
            $display("FAIL rst_in_delay got %h", {bus.addr_rom_a_o, bus.addr_rom_b_o, bus.valid_o, bus.busy_o, bus.done_o});
        end
        @(negedge clk);
        rst = 1'b0;
        adv(6);
        tests++;
        if ({bus.busy_o, bus.addr_rom_a_o} !== {1'b0, 4'd0}) begin
            fails++;
            $display("FAIL rst_stays_idle got %h expected 00", {bus.busy_o, bus.addr_rom_a_o});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_issue();
        test_backpressure();
        test_wait();
        test_wrap();
        test_jump_self();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
